// File: rtl/spi_servo_master.sv
// SPI mode-0 master that turns one parallel servo command into a 16-bit frame
// and returns the 16 bits clocked back on miso as a response word.
module spi_servo_master #(
    parameter int          CLK_DIV  = 4,
    parameter logic [3:0]  DEV_ADDR = 4'b1100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_use_addr,
    input  logic [3:0]  cmd_addr,
    input  logic [2:0]  cmd_chan,
    input  logic [7:0]  cmd_pos,
    output logic        busy,
    output logic        done,
    output logic [15:0] rsp_data,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        c_en
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
            $error("spi_servo_master: CLK_DIV must be in 2..255");
        end
    endgenerate

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_GAP  = 8'(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [3:0]  bit_reg, bit_next;
    logic [15:0] tx_reg, tx_next;
    logic [15:0] rx_reg, rx_next;
    logic [15:0] rsp_reg, rsp_next;
    logic        sclk_reg, sclk_next;
    logic        mosi_reg, mosi_next;
    logic        c_en_reg, c_en_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        ready_reg, ready_next;

    logic        accept;
    logic        div_end;
    logic [3:0]  frame_addr;
    logic [15:0] frame;

    assign accept     = cmd_valid && ready_reg;
    assign div_end    = (div_reg == DIV_LAST);
    assign frame_addr = cmd_use_addr ? cmd_addr : DEV_ADDR;
    assign frame      = {frame_addr, 1'b0, cmd_chan, cmd_pos};

    always_comb begin
        state_next = state_reg;
        div_next   = (state_reg == IDLE || div_end) ? 8'd0 : div_reg + 8'd1;
        bit_next   = bit_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        rsp_next   = rsp_reg;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        c_en_next  = c_en_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        ready_next = ready_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    tx_next    = frame;
                    rx_next    = 16'd0;
                    bit_next   = 4'd0;
                    div_next   = 8'd0;
                    mosi_next  = frame[15];
                    c_en_next  = 1'b1;
                    busy_next  = 1'b1;
                    ready_next = 1'b0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                        rx_next   = {rx_reg[14:0], miso};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_reg == 4'd15) begin
                            state_next = HOLD;
                        end else begin
                            // next bit goes out on the falling edge, half a period before the slave samples it
                            bit_next  = bit_reg + 4'd1;
                            tx_next   = {tx_reg[14:0], 1'b0};
                            mosi_next = tx_reg[14];
                        end
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    c_en_next  = 1'b0;
                    mosi_next  = 1'b0;
                    state_next = GAP;
                end
            end
            GAP: begin
                // one cycle longer than the other phases so done lands at accept + 35*CLK_DIV + 1
                div_next = (div_reg == DIV_GAP) ? 8'd0 : div_reg + 8'd1;
                if (div_reg == DIV_GAP) begin
                    done_next  = 1'b1;
                    rsp_next   = rx_reg;
                    busy_next  = 1'b0;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= 8'd0;
            bit_reg   <= 4'd0;
            tx_reg    <= 16'd0;
            rx_reg    <= 16'd0;
            rsp_reg   <= 16'd0;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            c_en_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            rsp_reg   <= rsp_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            c_en_reg  <= c_en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ready_reg <= ready_next;
        end
    end

    assign cmd_ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign rsp_data  = rsp_reg;
    assign sclk      = sclk_reg;
    assign mosi      = mosi_reg;
    assign c_en      = c_en_reg;

endmodule

// File: tb/tb_spi_servo_master.sv
// Randomized bench for spi_servo_master: a slave model drives miso, monitors
// capture the mosi stream and frame timing, and results are set against rule-derived values.
module tb_spi_servo_master;

    localparam int         D   = 4;
    localparam logic [3:0] DEV = 4'b1100;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_use_addr;
    logic [3:0]  cmd_addr;
    logic [2:0]  cmd_chan;
    logic [7:0]  cmd_pos;
    logic        busy;
    logic        done;
    logic [15:0] rsp_data;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        c_en;

    spi_servo_master #(
        .CLK_DIV  (D),
        .DEV_ADDR (DEV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_use_addr (cmd_use_addr),
        .cmd_addr     (cmd_addr),
        .cmd_chan     (cmd_chan),
        .cmd_pos      (cmd_pos),
        .busy         (busy),
        .done         (done),
        .rsp_data     (rsp_data),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .c_en         (c_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_frame = 0;
    logic [15:0] last_rsp = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mosi stream as seen by a slave sampling on sclk rising edges
    logic [15:0] mosi_cap = 16'd0;
    int          rise_cnt = 0;
    always @(posedge sclk) begin
        mosi_cap = {mosi_cap[14:0], mosi};
        rise_cnt++;
    end

    // slave: first response bit valid at select, later bits change on sclk fall
    logic [15:0] slave_q[$];
    logic [15:0] slave_word = 16'd0;
    int          slave_bit = 0;
    always @(posedge c_en) begin
        slave_word = (slave_q.size() > 0) ? slave_q.pop_front() : 16'd0;
        slave_bit  = 15;
        miso       = slave_word[15];
    end
    always @(negedge sclk) begin
        if (c_en === 1'b1 && slave_bit > 0) begin
            slave_bit--;
            miso = slave_word[slave_bit];
        end
    end

    // length of the most recent run of deselected cycles
    int low_run = 0;
    int last_low_run = 0;
    always @(negedge clk) begin
        if (c_en === 1'b1) begin
            if (low_run != 0) last_low_run = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    task automatic scramble_fields();
        cmd_use_addr = 1'($urandom);
        cmd_addr     = 4'($urandom);
        cmd_chan     = 3'($urandom);
        cmd_pos      = 8'($urandom);
    endtask

    task automatic idle(input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || c_en !== 1'b0 || sclk !== 1'b0)
                bad++;
        end
        check_eq("idle_quiet", 32'(bad), 32'd0);
    endtask

    // Caller must be at a falling clock edge with cmd_ready expected high.
    task automatic do_frame(input logic use_addr, input logic [3:0] addr, input logic [2:0] chan,
                            input logic [7:0] pos, input logic [15:0] sresp,
                            input bit hold_valid, input bit poke, input bit b2b);
        logic [15:0] exp_frame;
        int k, cen_cnt, done_at, bad_ctl, held_bad, r0;
        exp_frame = {(use_addr ? addr : DEV), 1'b0, chan, pos};
        check_eq("ready_before", 32'(cmd_ready), 32'd1);
        check_eq("rsp_held_before", 32'(rsp_data), 32'(last_rsp));
        slave_q.push_back(sresp);
        cmd_valid    = 1'b1;
        cmd_use_addr = use_addr;
        cmd_addr     = addr;
        cmd_chan     = chan;
        cmd_pos      = pos;
        @(posedge clk);
        r0 = rise_cnt;
        #1;
        if (!hold_valid) cmd_valid = 1'b0;
        scramble_fields();
        k = 0; cen_cnt = 0; done_at = -1; bad_ctl = 0; held_bad = 0;
        while (done_at < 0 && k < 40 * D + 20) begin
            @(negedge clk);
            if (c_en === 1'b1) cen_cnt++;
            if (done === 1'b1) begin
                done_at = k;
            end else begin
                if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_ctl++;
                if (rsp_data !== last_rsp) held_bad++;
            end
            if (poke && k == 60) begin
                cmd_valid = 1'b1;
                scramble_fields();
            end
            if (poke && k == 61 && !hold_valid) cmd_valid = 1'b0;
            k++;
        end
        check_eq("done_cycle", 32'(done_at), 32'(35 * D + 1));
        check_eq("cen_len", 32'(cen_cnt), 32'(34 * D));
        check_eq("sclk_rises", 32'(rise_cnt - r0), 32'd16);
        check_eq("mosi_frame", 32'(mosi_cap), 32'(exp_frame));
        check_eq("frame_bit11", 32'(mosi_cap[11]), 32'd0);
        check_eq("rsp_data", 32'(rsp_data), 32'(sresp));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("ready_at_done", 32'(cmd_ready), 32'd1);
        check_eq("ctl_during_frame", 32'(bad_ctl), 32'd0);
        check_eq("rsp_held_during", 32'(held_bad), 32'd0);
        if (b2b) check_eq("deselect_gap", 32'(last_low_run), 32'(D + 2));
        last_rsp = sresp;
        n_frame++;
        $display("frame %0d: mosi=0x%04h exp=0x%04h rsp=0x%04h exp=0x%04h done@%0d", n_frame,
                 mosi_cap, exp_frame, rsp_data, sresp, done_at);
    endtask

    task automatic abort_frame();
        int k, r0;
        slave_q.push_back(16'($urandom));
        cmd_valid = 1'b1;
        scramble_fields();
        @(posedge clk);
        r0 = rise_cnt;
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while ((rise_cnt - r0) < 8 && k < 40 * D) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_at_bit8", 32'(rise_cnt - r0), 32'd8);
        rst = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        check_eq("abort_c_en", 32'(c_en), 32'd0);
        check_eq("abort_sclk", 32'(sclk), 32'd0);
        check_eq("abort_mosi", 32'(mosi), 32'd0);
        check_eq("abort_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_rsp", 32'(rsp_data), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        last_rsp = 16'd0;
        $display("abort: reset applied after 8 sclk rises");
        idle(8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_use_addr = 1'b0;
        cmd_addr = 4'd0;
        cmd_chan = 3'd0;
        cmd_pos = 8'd0;
        miso = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rsp", 32'(rsp_data), 32'd0);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_c_en", 32'(c_en), 32'd0);
        rst = 1'b0;
        idle(3);

        do_frame(1'b0, 4'h0, 3'd3, 8'h5A, 16'hA55A, 1'b0, 1'b0, 1'b0);
        idle(2);
        do_frame(1'b1, 4'h3, 3'd7, 8'hFF, 16'($urandom), 1'b0, 1'b1, 1'b0);
        idle(4);
        do_frame(1'($urandom), 4'($urandom), 3'($urandom), 8'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
        do_frame(1'($urandom), 4'($urandom), 3'($urandom), 8'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        idle(2);
        abort_frame();
        do_frame(1'b0, 4'h0, 3'd1, 8'h80, 16'h1234, 1'b0, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            do_frame(1'($urandom), 4'($urandom), 3'($urandom), 8'($urandom), 16'($urandom),
                     1'b0, 1'($urandom), 1'b0);
            idle($urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
